// File: rtl/snake_collision_detector.sv
`default_nettype none
// ============================================================================
// Module   : snake_collision_detector
// Purpose  : Holds the snake body as a register array of grid cells, applies
//            one move per moveTick, then checks the new head against the walls
//            (before any arithmetic) and against every body segment (one
//            segment per cycle). collision is sticky until reset.
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous, active-high
//            moveTick   - one-cycle strobe, advance one cell
//            direction  - 00 up, 01 down, 10 left, 11 right
//            grow       - keep the tail on this move
//            collision  - wall or self hit, held until reset
//            busy       - body scan in progress
//            headX/headY- current head cell (seg[0])
//            length     - current segment count
// Revision : 1.0 - initial release
// ============================================================================
module snake_collision_detector #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_BITS   = 5,
    parameter int Y_BITS   = 5,
    parameter int MAX_LEN  = 32,
    parameter int LEN_BITS = 6,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 16,
    parameter int INIT_Y   = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                moveTick,
    input  logic [1:0]          direction,
    input  logic                grow,
    output logic                collision,
    output logic                busy,
    output logic [X_BITS-1:0]   headX,
    output logic [Y_BITS-1:0]   headY,
    output logic [LEN_BITS-1:0] length
);

    localparam int c_IDX_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_SCAN = 2'd1;
    localparam logic [1:0] c_S_HIT  = 2'd2;

    localparam logic [1:0] c_DIR_UP    = 2'b00;
    localparam logic [1:0] c_DIR_DOWN  = 2'b01;
    localparam logic [1:0] c_DIR_LEFT  = 2'b10;
    localparam logic [1:0] c_DIR_RIGHT = 2'b11;

    localparam logic [X_BITS-1:0]   c_X_ONE   = X_BITS'(1);
    localparam logic [Y_BITS-1:0]   c_Y_ONE   = Y_BITS'(1);
    localparam logic [X_BITS-1:0]   c_X_MAX   = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0]   c_Y_MAX   = Y_BITS'(GRID_H - 1);
    localparam logic [LEN_BITS-1:0] c_LEN_ONE = LEN_BITS'(1);
    localparam logic [LEN_BITS-1:0] c_LEN_MAX = LEN_BITS'(MAX_LEN);

    logic [X_BITS-1:0]   r_seg_x [0:MAX_LEN-1];
    logic [Y_BITS-1:0]   r_seg_y [0:MAX_LEN-1];
    logic [LEN_BITS-1:0] r_length;
    logic [LEN_BITS-1:0] r_idx;
    logic [1:0]          r_last_dir;
    logic [1:0]          r_state;
    logic                r_collision;
    logic                r_busy;

    logic                  w_reverse;
    logic [1:0]            w_eff_dir;
    logic                  w_wall;
    logic [X_BITS-1:0]     w_new_x;
    logic [Y_BITS-1:0]     w_new_y;
    logic [c_IDX_BITS-1:0] w_idx;
    logic                  w_match;
    logic                  w_scan_last;

    // Direction decode and wall check. The wall test looks at the old head,
    // so the +/-1 below can never wrap when it is actually used.
    always_comb begin
        w_reverse = (direction == {r_last_dir[1], ~r_last_dir[0]});
        w_eff_dir = w_reverse ? r_last_dir : direction;
        w_wall    = 1'b0;
        w_new_x   = r_seg_x[0];
        w_new_y   = r_seg_y[0];
        case (w_eff_dir)
            c_DIR_UP: begin
                w_wall  = (r_seg_y[0] == '0);
                w_new_y = r_seg_y[0] - c_Y_ONE;
            end
            c_DIR_DOWN: begin
                w_wall  = (r_seg_y[0] == c_Y_MAX);
                w_new_y = r_seg_y[0] + c_Y_ONE;
            end
            c_DIR_LEFT: begin
                w_wall  = (r_seg_x[0] == '0);
                w_new_x = r_seg_x[0] - c_X_ONE;
            end
            default: begin
                w_wall  = (r_seg_x[0] == c_X_MAX);
                w_new_x = r_seg_x[0] + c_X_ONE;
            end
        endcase
    end

    // Scan compare: r_idx never exceeds length-1 < MAX_LEN, so the low bits
    // are a safe array index.
    always_comb begin
        w_idx       = r_idx[c_IDX_BITS-1:0];
        w_match     = (r_seg_x[w_idx] == r_seg_x[0]) && (r_seg_y[w_idx] == r_seg_y[0]);
        w_scan_last = (r_idx == (r_length - c_LEN_ONE));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? X_BITS'(INIT_X - i) : '0;
                r_seg_y[i] <= (i < INIT_LEN) ? Y_BITS'(INIT_Y) : '0;
            end
            r_length    <= LEN_BITS'(INIT_LEN);
            r_idx       <= '0;
            r_last_dir  <= c_DIR_RIGHT;
            r_state     <= c_S_IDLE;
            r_collision <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (moveTick) begin
                        r_last_dir <= w_eff_dir;
                        if (w_wall) begin
                            r_state     <= c_S_HIT;
                            r_collision <= 1'b1;
                        end else begin
                            for (int i = MAX_LEN - 1; i >= 1; i--) begin
                                r_seg_x[i] <= r_seg_x[i-1];
                                r_seg_y[i] <= r_seg_y[i-1];
                            end
                            r_seg_x[0] <= w_new_x;
                            r_seg_y[0] <= w_new_y;
                            if (grow && (r_length < c_LEN_MAX)) begin
                                r_length <= r_length + c_LEN_ONE;
                            end
                            r_idx   <= c_LEN_ONE;
                            r_busy  <= 1'b1;
                            r_state <= c_S_SCAN;
                        end
                    end
                end
                c_S_SCAN: begin
                    if (w_match) begin
                        r_state     <= c_S_HIT;
                        r_collision <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (w_scan_last) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + c_LEN_ONE;
                    end
                end
                c_S_HIT: begin
                    r_collision <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign collision = r_collision;
    assign busy      = r_busy;
    assign headX     = r_seg_x[0];
    assign headY     = r_seg_y[0];
    assign length    = r_length;

endmodule
`default_nettype wire

// File: tb/tb_snake_collision_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_collision_detector
// Purpose  : Directed and randomized checks of snake_collision_detector
//            against a queue-based model of the snake on the grid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_collision_detector;

    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int MAX_LEN = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       moveTick = 1'b0;
    logic [1:0] direction = 2'b11;
    logic       grow = 1'b0;
    logic       collision;
    logic       busy;
    logic [4:0] headX;
    logic [4:0] headY;
    logic [5:0] length;

    int tests = 0;
    int fails = 0;

    // Model: body cells head-first, last accepted direction, game-over flag.
    int       mx[$];
    int       my[$];
    int       m_last;
    bit       m_hit;

    snake_collision_detector dut (
        .clock     (clock),
        .reset     (reset),
        .moveTick  (moveTick),
        .direction (direction),
        .grow      (grow),
        .collision (collision),
        .busy      (busy),
        .headX     (headX),
        .headY     (headY),
        .length    (length)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = {};
        my = {};
        for (int i = 0; i < 3; i++) begin
            mx.push_back(16 - i);
            my.push_back(12);
        end
        m_last = 3;
        m_hit  = 1'b0;
    endtask

    function automatic bit opposite(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) ||
               (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".headX"},  32'(headX),  32'(mx[0]));
        check({tag, ".headY"},  32'(headY),  32'(my[0]));
        check({tag, ".length"}, 32'(length), 32'(mx.size()));
    endtask

    task automatic do_reset();
        moveTick = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        check_state("reset");
        check("reset.collision", 32'(collision), 32'd0);
        check("reset.busy",      32'(busy),      32'd0);
        reset = 1'b0;
    endtask

    // One move. If inject is set, a second moveTick (dir up) is pulsed during
    // the scan; it must be dropped entirely.
    task automatic do_tick(input int d, input bit g, input bit inject, input string tag);
        int  e, nx, ny, exp_cycles, c;
        bit  was_hit, wall, self_hit;
        was_hit    = m_hit;
        wall       = 1'b0;
        self_hit   = 1'b0;
        exp_cycles = 0;
        if (!m_hit) begin
            e      = opposite(d, m_last) ? m_last : d;
            m_last = e;
            nx = mx[0];
            ny = my[0];
            case (e)
                0: ny = ny - 1;
                1: ny = ny + 1;
                2: nx = nx - 1;
                default: nx = nx + 1;
            endcase
            if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
                wall  = 1'b1;
                m_hit = 1'b1;
            end else begin
                mx.push_front(nx);
                my.push_front(ny);
                if (!(g && mx.size() <= MAX_LEN)) begin
                    void'(mx.pop_back());
                    void'(my.pop_back());
                end
                exp_cycles = mx.size() - 1;
                for (int k = 1; k < mx.size(); k++) begin
                    if (mx[k] == nx && my[k] == ny) begin
                        exp_cycles = k;
                        self_hit   = 1'b1;
                        m_hit      = 1'b1;
                        break;
                    end
                end
            end
        end

        @(negedge clock);
        moveTick  = 1'b1;
        direction = 2'(d);
        grow      = g;
        @(posedge clock);
        #1;
        moveTick = 1'b0;
        grow     = 1'b0;
        check_state(tag);

        if (was_hit || wall) begin
            check({tag, ".collision"}, 32'(collision), 32'd1);
            check({tag, ".busy"},      32'(busy),      32'd0);
        end else begin
            check({tag, ".busy_start"}, 32'(busy), 32'd1);
            c = 0;
            while (busy && c < 64) begin
                if (inject && c == 0) begin
                    @(negedge clock);
                    moveTick  = 1'b1;
                    direction = 2'b00;
                end
                @(posedge clock);
                #1;
                moveTick = 1'b0;
                c++;
                if (busy) check({tag, ".coll_during_scan"}, 32'(collision), 32'd0);
            end
            check({tag, ".scan_cycles"}, 32'(c), 32'(exp_cycles));
            check({tag, ".collision"},   32'(collision), 32'(self_hit));
            if (inject) check_state({tag, ".dropped"});
        end
    endtask

    initial begin
        model_reset();

        // Reset state, including the two trailing segments.
        do_reset();
        check("reset.seg1x", 32'(dut.r_seg_x[1]), 32'd15);
        check("reset.seg1y", 32'(dut.r_seg_y[1]), 32'd12);
        check("reset.seg2x", 32'(dut.r_seg_x[2]), 32'd14);
        check("reset.seg2y", 32'(dut.r_seg_y[2]), 32'd12);

        // Run right to the wall, then into it.
        for (int i = 0; i < 15; i++) do_tick(3, 1'b0, 1'b0, "right_run");
        check("edge.headX", 32'(headX), 32'd31);
        do_tick(3, 1'b0, 1'b0, "right_wall");
        do_tick(0, 1'b0, 1'b0, "after_hit");

        // Reversal request is treated as the previous direction.
        do_reset();
        do_tick(2, 1'b0, 1'b0, "reverse");
        check("reverse.headX", 32'(headX), 32'd17);

        // Length 5, then a tight loop into the body.
        do_reset();
        do_tick(3, 1'b1, 1'b0, "grow1");
        do_tick(3, 1'b1, 1'b0, "grow2");
        do_tick(0, 1'b0, 1'b0, "loop5_up");
        do_tick(2, 1'b0, 1'b0, "loop5_left");
        do_tick(1, 1'b0, 1'b0, "loop5_down");

        // Length 4: entering the cell the tail just left is legal.
        do_reset();
        do_tick(3, 1'b1, 1'b0, "grow4");
        do_tick(0, 1'b0, 1'b0, "loop4_up");
        do_tick(2, 1'b0, 1'b0, "loop4_left");
        do_tick(1, 1'b0, 1'b0, "loop4_down");

        // A tick during a scan is dropped and does not touch lastDir.
        do_reset();
        do_tick(3, 1'b1, 1'b0, "drop_g1");
        do_tick(3, 1'b1, 1'b0, "drop_g2");
        do_tick(3, 1'b0, 1'b1, "drop_scan");
        do_tick(1, 1'b0, 1'b0, "drop_next");

        // Reset two cycles into a scan.
        do_reset();
        do_tick(3, 1'b1, 1'b0, "rst_g1");
        do_tick(3, 1'b1, 1'b0, "rst_g2");
        @(negedge clock);
        moveTick  = 1'b1;
        direction = 2'b00;
        @(posedge clock);
        #1;
        moveTick = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("midscan.busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state("midscan_rst");
        check("midscan_rst.collision", 32'(collision), 32'd0);
        check("midscan_rst.busy",      32'(busy),      32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Random walks until game over (or a move budget runs out).
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int t = 0; t < 60 && !m_hit; t++) begin
                do_tick(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 1'b0, "random");
            end
            do_tick(int'($urandom_range(0, 3)), 1'b1, 1'b0, "random_tail");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
